// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type and address-split helpers for the fetch stage
package fetch_pkg;

    typedef enum logic {
        LOOKUP = 1'b0,
        FILL   = 1'b1
    } fetch_state_t;

    // Byte-offset bits below the word offset; always ignored for lookup.
    localparam int BYTE_BITS = 2;

    function automatic int ow_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int iw_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int aw, input int sets, input int words_per_line);
        return aw - BYTE_BITS - $clog2(sets) - $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - valid/tag/data arrays of the direct-mapped instruction cache
module icache_line_store #(
    parameter int SETS           = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_W         = 32,
    parameter int TAG_W          = 25,
    parameter int IW             = 3,
    parameter int OW             = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_all,
    input  logic [IW-1:0]     rd_index,
    input  logic [OW-1:0]     rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_index,
    input  logic [OW-1:0]     wr_word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              set_en,
    input  logic [IW-1:0]     set_index,
    input  logic [TAG_W-1:0]  set_tag
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS*WORDS_PER_LINE];

    // Valid bits: cleared together on reset or flush, set one line at a time when a fill lands.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            valid_q <= '0;
        end else if (set_en) begin
            valid_q[set_index] <= 1'b1;
        end
    end

    // Tag written alongside the valid bit at the end of a fill.
    always_ff @(posedge clk) begin
        if (set_en) begin
            tag_q[set_index] <= set_tag;
        end
    end

    // Data words written one beat at a time, addressed as {line, word}.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_word}];

endmodule

// File: rtl/fetch_icache.sv
// rtl/fetch_icache.sv - PC, next-PC logic and line-fill FSM around a direct-mapped instruction cache
import fetch_pkg::*;

module fetch_icache #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATAOUT_WIDTH  = 32,
    parameter int SETS           = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trigger,
    input  logic                     PCSrc,
    input  logic                     jalrmuxSel,
    input  logic [DATAOUT_WIDTH-1:0] ImmOp,
    input  logic [ADDRESS_WIDTH-1:0] rd1,
    input  logic                     flush,
    output logic [DATAOUT_WIDTH-1:0] RD,
    output logic [ADDRESS_WIDTH-1:0] PC_out,
    output logic                     instr_valid,
    output logic                     stall,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_valid,
    input  logic [DATAOUT_WIDTH-1:0] mem_rdata,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);

    localparam int OW = ow_bits(WORDS_PER_LINE);
    localparam int IW = iw_bits(SETS);
    localparam int TW = tag_bits(ADDRESS_WIDTH, SETS, WORDS_PER_LINE);
    localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS_PER_LINE - 1);

    fetch_state_t             state_q;
    logic [OW-1:0]            beat_q;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic [ADDRESS_WIDTH-1:0] imm_a;
    logic [ADDRESS_WIDTH-1:0] jalr_sum;

    logic [IW-1:0] pc_index;
    logic [OW-1:0] pc_word;
    logic [TW-1:0] pc_tag;
    logic          line_valid;
    logic [TW-1:0] line_tag;
    logic          hit;
    logic          lookup;
    logic          beat_done;
    logic          line_done;

    assign pc_index = pc_q[BYTE_BITS+OW +: IW];
    assign pc_word  = pc_q[BYTE_BITS +: OW];
    assign pc_tag   = pc_q[ADDRESS_WIDTH-1 -: TW];

    assign lookup      = (state_q == LOOKUP);
    assign hit         = line_valid && (line_tag == pc_tag);
    assign instr_valid = lookup && hit;
    assign stall       = ~instr_valid;
    assign PC_out      = pc_q;

    // While filling, the PC is frozen so its line base names the line being filled.
    assign mem_req   = (state_q == FILL);
    assign mem_addr  = {pc_q[ADDRESS_WIDTH-1:BYTE_BITS+OW], beat_q, {BYTE_BITS{1'b0}}};
    assign beat_done = mem_req && mem_valid && !flush;
    assign line_done = beat_done && (beat_q == LAST_BEAT);

    icache_line_store #(
        .SETS          (SETS),
        .WORDS_PER_LINE(WORDS_PER_LINE),
        .DATA_W        (DATAOUT_WIDTH),
        .TAG_W         (TW),
        .IW            (IW),
        .OW            (OW)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .clear_all(flush),
        .rd_index (pc_index),
        .rd_word  (pc_word),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (RD),
        .wr_en    (beat_done),
        .wr_index (pc_index),
        .wr_word  (beat_q),
        .wr_data  (mem_rdata),
        .set_en   (line_done),
        .set_index(pc_index),
        .set_tag  (pc_tag)
    );

    assign imm_a    = ADDRESS_WIDTH'(ImmOp);
    assign jalr_sum = rd1 + imm_a;

    // Next-PC select: sequential, PC-relative, or register-relative with bit 0 cleared.
    always_comb begin
        pc_next = pc_q + ADDRESS_WIDTH'(4);
        if (PCSrc) begin
            if (jalrmuxSel) begin
                pc_next = {jalr_sum[ADDRESS_WIDTH-1:1], 1'b0};
            end else begin
                pc_next = pc_q + imm_a;
            end
        end
    end

    // Line-fill FSM: a miss starts a fill at beat 0; flush abandons it without writing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOOKUP;
            beat_q  <= '0;
        end else begin
            case (state_q)
                LOOKUP: begin
                    if (!hit) begin
                        state_q <= FILL;
                        beat_q  <= '0;
                    end
                end
                FILL: begin
                    if (flush) begin
                        state_q <= LOOKUP;
                        beat_q  <= '0;
                    end else if (mem_valid) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q <= LOOKUP;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + OW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= LOOKUP;
                    beat_q  <= '0;
                end
            endcase
        end
    end

    // PC advances only on a hit while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (trigger && instr_valid) begin
            pc_q <= pc_next;
        end
    end

    // Saturating hit/miss counters over running lookup cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (lookup && trigger) begin
            if (hit) begin
                if (hit_count != '1) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else if (miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_icache.sv
// tb/tb_fetch_icache.sv - randomized and directed checks of fetch_icache against a queue-based cache model
module tb_fetch_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger;
    logic        PCSrc;
    logic        jalrmuxSel;
    logic [31:0] ImmOp;
    logic [31:0] rd1;
    logic        flush;
    logic [31:0] RD;
    logic [31:0] PC_out;
    logic        instr_valid;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    fetch_icache dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .PCSrc      (PCSrc),
        .jalrmuxSel (jalrmuxSel),
        .ImmOp      (ImmOp),
        .rd1        (rd1),
        .flush      (flush),
        .RD         (RD),
        .PC_out     (PC_out),
        .instr_valid(instr_valid),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: PC, counters, per-line valid/tag, and the word addresses still owed by a fill.
    logic [31:0] m_pc;
    logic [31:0] m_hits;
    logic [31:0] m_misses;
    bit          m_valid [8];
    logic [24:0] m_tag   [8];
    logic [31:0] m_pend  [$];
    logic [31:0] seen_beats [$];

    // Memory: 0 = zero wait, 1 = answers on 3rd cycle of each beat, 2 = random 0..3 waits.
    int wait_mode;
    int wcnt;
    int wtarget;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic bit m_hit();
        return m_valid[m_pc[6:4]] && (m_tag[m_pc[6:4]] == m_pc[31:7]);
    endfunction

    function automatic int pick_wait();
        if (wait_mode == 0) return 0;
        if (wait_mode == 1) return 2;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'd0;
        m_hits   = 32'd0;
        m_misses = 32'd0;
        m_pend.delete();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endtask

    // Drive memory response for this cycle, let outputs settle, compare against the model.
    task automatic sample();
        bit filling;
        bit h;
        if (mem_req) mem_valid = (wcnt >= wtarget);
        else         mem_valid = 1'($urandom_range(0, 1));
        mem_rdata = memw(mem_addr);
        #1;
        filling = (m_pend.size() != 0);
        h = !filling && m_hit();
        chk("pc", PC_out, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(h));
        chk("stall", 32'(stall), 32'(!h));
        chk("mem_req", 32'(mem_req), 32'(filling));
        if (filling) chk("mem_addr", mem_addr, m_pend[0]);
        if (h) chk("rd", RD, memw({m_pc[31:2], 2'b00}));
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
    endtask

    // Predict the effect of this cycle's inputs, then move to the next cycle.
    task automatic advance();
        bit filling;
        bit h;
        filling = (m_pend.size() != 0);
        h = !filling && m_hit();
        if (mem_req && mem_valid) seen_beats.push_back(mem_addr);
        if (mem_req && mem_valid) begin
            wcnt = 0;
            wtarget = pick_wait();
        end else if (mem_req) begin
            wcnt++;
        end else begin
            wcnt = 0;
            wtarget = pick_wait();
        end
        if (rst) begin
            model_reset();
        end else if (filling) begin
            if (flush) begin
                m_pend.delete();
                foreach (m_valid[i]) m_valid[i] = 1'b0;
            end else if (mem_valid) begin
                void'(m_pend.pop_front());
                if (m_pend.size() == 0) begin
                    m_valid[m_pc[6:4]] = 1'b1;
                    m_tag[m_pc[6:4]]   = m_pc[31:7];
                end
            end
        end else begin
            if (trigger) begin
                if (h) m_hits   = (m_hits   == 32'hFFFFFFFF) ? m_hits   : m_hits + 32'd1;
                else   m_misses = (m_misses == 32'hFFFFFFFF) ? m_misses : m_misses + 32'd1;
            end
            if (!h) begin
                for (int w = 0; w < 4; w++) m_pend.push_back({m_pc[31:4], 4'b0000} + 32'(4 * w));
            end else if (trigger) begin
                if (!PCSrc)          m_pc = m_pc + 32'd4;
                else if (!jalrmuxSel) m_pc = m_pc + ImmOp;
                else                 m_pc = (rd1 + ImmOp) & 32'hFFFFFFFE;
            end
            if (flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_hit(input string name, input int budget);
        int n;
        n = 0;
        sample();
        while (!instr_valid && n < budget) begin
            advance();
            sample();
            n++;
        end
        chk({name, " reached hit"}, 32'(instr_valid), 32'd1);
    endtask

    task automatic jump(input logic j, input logic [31:0] r, input logic [31:0] imm);
        PCSrc = 1'b1;
        jalrmuxSel = j;
        rd1 = r;
        ImmOp = imm;
        advance();
        PCSrc = 1'b0;
        jalrmuxSel = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_valid;
        int fill_cycles;

        rst = 1'b1; trigger = 1'b0; PCSrc = 1'b0; jalrmuxSel = 1'b0;
        ImmOp = 32'd0; rd1 = 32'd0; flush = 1'b0; mem_valid = 1'b0; mem_rdata = 32'd0;
        wait_mode = 0; wcnt = 0; wtarget = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);

        // Reset state
        sample();
        chk("reset pc", PC_out, 32'h0);
        chk("reset instr_valid", 32'(instr_valid), 32'd0);
        chk("reset stall", 32'(stall), 32'd1);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset hit_count", hit_count, 32'd0);
        chk("reset miss_count", miss_count, 32'd0);
        advance();

        // Cold start: miss, four zero-wait beats, then consecutive hits
        rst = 1'b0; trigger = 1'b1;
        seen_beats.delete();
        first_valid = -1;
        for (int k = 0; k < 9; k++) begin
            sample();
            if (instr_valid && first_valid < 0) first_valid = k;
            if (k >= 5) chk("cold pc", PC_out, 32'((k - 5) * 4));
            advance();
        end
        chk("cold first valid cycle", 32'(first_valid), 32'd5);
        chk("cold beat count", 32'(seen_beats.size()), 32'd4);
        for (int i = 0; i < seen_beats.size() && i < 4; i++) chk("cold mem_addr", seen_beats[i], 32'(4 * i));
        sample();
        chk("cold hit_count", hit_count, 32'd4);
        chk("cold miss_count", miss_count, 32'd1);
        chk("cold pc after", PC_out, 32'h10);

        // Fill line 1, then jalr and branch back into line 0
        wait_hit("line1", 20);
        jump(1'b1, 32'h5, 32'h3);
        sample();
        chk("jalr to 0x8", PC_out, 32'h8);
        chk("0x8 hit", 32'(instr_valid), 32'd1);
        jump(1'b0, 32'h0, 32'hFFFFFFF8);
        sample();
        chk("branch to 0x0", PC_out, 32'h0);
        chk("miss count before conflict", miss_count, 32'd2);

        // Conflict miss on the same index, then back again
        seen_beats.delete();
        jump(1'b0, 32'h0, 32'h80);
        sample();
        chk("conflict pc", PC_out, 32'h80);
        chk("conflict misses", 32'(instr_valid), 32'd0);
        wait_hit("0x80", 20);
        chk("miss count after 0x80", miss_count, 32'd3);
        if (seen_beats.size() > 0) chk("0x80 fill base", seen_beats[0], 32'h80);
        else chk("0x80 fill beats", 32'd0, 32'd4);
        seen_beats.delete();
        jump(1'b0, 32'h0, 32'hFFFFFF80);
        sample();
        chk("return pc", PC_out, 32'h0);
        chk("return misses", 32'(instr_valid), 32'd0);
        wait_hit("refill 0x0", 20);
        chk("miss count after return", miss_count, 32'd4);
        if (seen_beats.size() > 0) chk("refill base", seen_beats[0], 32'h0);
        else chk("refill beats", 32'd0, 32'd4);
        advance();
        sample();
        advance();
        sample();
        chk("seq to 0x8", PC_out, 32'h8);

        // jalr to 0x104, filled through a 3-cycle-per-beat memory
        wait_mode = 1;
        jump(1'b1, 32'h101, 32'h4);
        fill_cycles = 0;
        for (int n = 0; n < 60; n++) begin
            sample();
            if (instr_valid) break;
            if (mem_req) fill_cycles++;
            advance();
        end
        chk("jalr to 0x104", PC_out, 32'h104);
        chk("wait-state fill cycles", 32'(fill_cycles), 32'd12);
        chk("wait-state hit", 32'(instr_valid), 32'd1);
        chk("wait-state rd", RD, memw(32'h104));

        // trigger low on a hit holds PC and counters
        trigger = 1'b0;
        for (int n = 0; n < 3; n++) begin
            advance();
            sample();
        end
        chk("hold pc", PC_out, 32'h104);
        trigger = 1'b1;
        wait_mode = 0;

        // Flush on beat 2 of a fill to 0x200
        jump(1'b0, 32'h0, 32'hFC);
        sample();
        advance();
        sample();
        advance();
        sample();
        advance();
        sample();
        chk("flush beat addr", mem_addr, 32'h208);
        flush = 1'b1;
        advance();
        flush = 1'b0;
        sample();
        chk("flush mem_req", 32'(mem_req), 32'd0);
        chk("flush misses again", 32'(instr_valid), 32'd0);
        chk("flush pc", PC_out, 32'h200);
        advance();
        sample();
        chk("refill restart req", 32'(mem_req), 32'd1);
        chk("refill restart addr", mem_addr, 32'h200);
        wait_hit("after flush", 20);

        // Reset in the middle of a fill to 0x300
        jump(1'b0, 32'h0, 32'h100);
        sample();
        advance();
        sample();
        advance();
        sample();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        sample();
        chk("rst pc", PC_out, 32'h0);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst hit_count", hit_count, 32'd0);
        chk("rst miss_count", miss_count, 32'd0);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        advance();
        sample();
        chk("rst refill addr", mem_addr, 32'h0);
        wait_hit("after rst", 20);

        // Random traffic with random memory latency
        wait_mode = 2;
        for (int n = 0; n < 3000; n++) begin
            trigger    = ($urandom_range(0, 3) != 0);
            PCSrc      = ($urandom_range(0, 4) == 0);
            jalrmuxSel = 1'($urandom_range(0, 1));
            ImmOp      = (32'($urandom_range(0, 255)) - 32'd128) << 2;
            if ($urandom_range(0, 7) == 0) ImmOp = ImmOp + 32'($urandom_range(0, 3));
            rd1        = 32'($urandom_range(0, 1023));
            flush      = ($urandom_range(0, 49) == 0);
            rst        = ($urandom_range(0, 399) == 0);
            sample();
            advance();
        end
        rst = 1'b0;
        flush = 1'b0;
        sample();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
